// File: rtl/mips_ctrl_pkg.sv
// Shared encodings, opcode/funct constants, state and instruction-class types
// for the multi-cycle MIPS control sequencer.
package mips_ctrl_pkg;

  localparam int unsigned OP_W = 6;
  localparam int unsigned FN_W = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  localparam logic [FN_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FN_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FN_W-1:0] FN_AND = 6'b100100;
  localparam logic [FN_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FN_W-1:0] FN_XOR = 6'b100110;
  localparam logic [FN_W-1:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_OR  = 3'b010,
    ALU_SLT = 3'b011, ALU_AND = 3'b100, ALU_XOR = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {EXT_SIGNED = 2'b00, EXT_UNSIGNED = 2'b01, EXT_LUI = 2'b10} ext_type_e;
  typedef enum logic [1:0] {RD_RT = 2'b00, RD_RD = 2'b01, RD_RA = 2'b10} reg_dst_e;
  typedef enum logic [1:0] {M2R_MEM = 2'b00, M2R_ALU = 2'b01, M2R_PC = 2'b10} mem_to_reg_e;
  typedef enum logic [1:0] {PCS_ALU = 2'b00, PCS_ALUOUT = 2'b01, PCS_JUMP = 2'b10} pc_src_e;
  typedef enum logic [1:0] {ASB_RT = 2'b00, ASB_FOUR = 2'b01, ASB_IMM = 2'b10, ASB_BRANCH = 2'b11} alu_src_b_e;

  typedef enum logic [2:0] {
    S_INIT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  // R-type ops get their own class so EXEC never needs funct again
  typedef enum logic [3:0] {
    C_NONE, C_ADD, C_SUB, C_AND, C_OR, C_SLT, C_XOR,
    C_ADDI, C_ADDIU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL
  } instr_class_e;

  typedef struct packed {
    logic        mem_req;
    logic        mem_we;
    logic        i_or_d;
    logic        ir_write;
    logic        pc_write;
    pc_src_e     pc_src;
    logic        alu_src_a;
    alu_src_b_e  alu_src_b;
    alu_op_e     alu_op;
    ext_type_e   ext_type;
    reg_dst_e    reg_dst;
    mem_to_reg_e mem_to_reg;
    logic        reg_write;
    logic        illegal;
    logic        retire;
  } ctrl_t;

  function automatic alu_op_e cls_alu_op(input instr_class_e cls);
    case (cls)
      C_SUB, C_BEQ: return ALU_SUB;
      C_OR, C_ORI:  return ALU_OR;
      C_SLT:        return ALU_SLT;
      C_AND:        return ALU_AND;
      C_XOR:        return ALU_XOR;
      default:      return ALU_ADD;
    endcase
  endfunction

  function automatic ext_type_e cls_ext_type(input instr_class_e cls);
    case (cls)
      C_ADDIU, C_ORI: return EXT_UNSIGNED;
      C_LUI:          return EXT_LUI;
      default:        return EXT_SIGNED;
    endcase
  endfunction

  function automatic logic cls_is_rtype(input instr_class_e cls);
    return cls inside {C_ADD, C_SUB, C_AND, C_OR, C_SLT, C_XOR};
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Shared memory port handshake between the control sequencer and memory.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic i_or_d;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output i_or_d, input mem_ready);
  modport slave  (input mem_req, input mem_we, input i_or_d, output mem_ready);
endinterface

// File: rtl/instr_class_dec.sv
// Combinational opcode/funct to instruction-class decoder with a valid flag.
module instr_class_dec
  import mips_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] i_opcode,
  input  logic [FN_W-1:0] i_funct,
  output instr_class_e    o_cls_c,
  output logic            o_valid_c
);

  always_comb begin
    o_cls_c   = C_NONE;
    o_valid_c = 1'b1;
    case (i_opcode)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADD:  o_cls_c = C_ADD;
          FN_SUB:  o_cls_c = C_SUB;
          FN_AND:  o_cls_c = C_AND;
          FN_OR:   o_cls_c = C_OR;
          FN_SLT:  o_cls_c = C_SLT;
          FN_XOR:  o_cls_c = C_XOR;
          default: o_valid_c = 1'b0;
        endcase
      end
      OP_ADDI:  o_cls_c = C_ADDI;
      OP_ADDIU: o_cls_c = C_ADDIU;
      OP_ORI:   o_cls_c = C_ORI;
      OP_LUI:   o_cls_c = C_LUI;
      OP_LW:    o_cls_c = C_LW;
      OP_SW:    o_cls_c = C_SW;
      OP_BEQ:   o_cls_c = C_BEQ;
      OP_J:     o_cls_c = C_J;
      OP_JAL:   o_cls_c = C_JAL;
      default:  o_valid_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB over a shared req/ready memory port.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [OP_W-1:0]       opcode,
  input  logic [FN_W-1:0]       funct,
  input  logic                  alu_zero,
  multicycle_ctrl_if.master     mem,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic [1:0]            pc_src,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [2:0]            alu_op,
  output logic [1:0]            ext_type,
  output logic [1:0]            reg_dst,
  output logic [1:0]            mem_to_reg,
  output logic                  reg_write,
  output logic                  illegal,
  output logic                  retire,
  output logic [CNT_W-1:0]      retired_cnt
);

  state_e       r_state;
  state_e       w_state_nxt;
  instr_class_e r_cls;
  instr_class_e w_cls;
  logic         w_valid;
  ctrl_t        w_ctrl;
  logic [CNT_W-1:0] r_retired_cnt;

  instr_class_dec u_dec (
    .i_opcode  (opcode),
    .i_funct   (funct),
    .o_cls_c   (w_cls),
    .o_valid_c (w_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_INIT;
    else        r_state <= w_state_nxt;
  end

  // Class is captured at the end of DECODE and used by EXEC/MEM/WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_cls <= C_NONE;
    else if (r_state == S_DECODE) r_cls <= w_cls;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           r_retired_cnt <= '0;
    else if (w_ctrl.retire) r_retired_cnt <= r_retired_cnt + CNT_W'(1);
  end

  always_comb begin
    w_ctrl      = '0;
    w_state_nxt = r_state;
    case (r_state)
      S_INIT: w_state_nxt = S_FETCH;

      S_FETCH: begin
        w_ctrl.mem_req   = 1'b1;
        w_ctrl.alu_src_b = ASB_FOUR;
        w_ctrl.alu_op    = ALU_ADD;
        if (mem.mem_ready) begin
          w_ctrl.ir_write = 1'b1;
          w_ctrl.pc_write = 1'b1;
          w_ctrl.pc_src   = PCS_ALU;
          w_state_nxt     = S_DECODE;
        end
      end

      S_DECODE: begin
        w_ctrl.alu_src_b = ASB_BRANCH;
        w_ctrl.alu_op    = ALU_ADD;
        if (!w_valid) begin
          w_state_nxt = S_TRAP;
        end else if (w_cls == C_J || w_cls == C_JAL) begin
          w_ctrl.pc_write = 1'b1;
          w_ctrl.pc_src   = PCS_JUMP;
          w_ctrl.retire   = 1'b1;
          w_state_nxt     = S_FETCH;
          if (w_cls == C_JAL) begin
            w_ctrl.reg_write  = 1'b1;
            w_ctrl.reg_dst    = RD_RA;
            w_ctrl.mem_to_reg = M2R_PC;
          end
        end else begin
          w_state_nxt = S_EXEC;
        end
      end

      S_EXEC: begin
        w_ctrl.alu_src_a = 1'b1;
        w_ctrl.alu_op    = cls_alu_op(r_cls);
        w_ctrl.ext_type  = cls_ext_type(r_cls);
        w_ctrl.alu_src_b = cls_is_rtype(r_cls) ? ASB_RT : ASB_IMM;
        w_state_nxt      = S_WB;
        case (r_cls)
          C_LW, C_SW: w_state_nxt = S_MEM;
          C_BEQ: begin
            w_ctrl.alu_src_b = ASB_RT;
            w_ctrl.pc_write  = alu_zero;
            w_ctrl.pc_src    = PCS_ALUOUT;
            w_ctrl.retire    = 1'b1;
            w_state_nxt      = S_FETCH;
          end
          default: ;
        endcase
      end

      S_MEM: begin
        w_ctrl.mem_req = 1'b1;
        w_ctrl.i_or_d  = 1'b1;
        w_ctrl.mem_we  = (r_cls == C_SW);
        if (mem.mem_ready) begin
          if (r_cls == C_SW) begin
            w_ctrl.retire = 1'b1;
            w_state_nxt   = S_FETCH;
          end else begin
            w_state_nxt   = S_WB;
          end
        end
      end

      S_WB: begin
        w_ctrl.reg_write = 1'b1;
        w_ctrl.retire    = 1'b1;
        w_state_nxt      = S_FETCH;
        if (cls_is_rtype(r_cls)) begin
          w_ctrl.reg_dst    = RD_RD;
          w_ctrl.mem_to_reg = M2R_ALU;
        end else if (r_cls == C_LW) begin
          w_ctrl.reg_dst    = RD_RT;
          w_ctrl.mem_to_reg = M2R_MEM;
        end else begin
          w_ctrl.reg_dst    = RD_RT;
          w_ctrl.mem_to_reg = M2R_ALU;
        end
      end

      S_TRAP: w_ctrl.illegal = 1'b1;

      default: w_state_nxt = S_INIT;
    endcase
  end

  assign mem.mem_req  = w_ctrl.mem_req;
  assign mem.mem_we   = w_ctrl.mem_we;
  assign mem.i_or_d   = w_ctrl.i_or_d;
  assign ir_write     = w_ctrl.ir_write;
  assign pc_write     = w_ctrl.pc_write;
  assign pc_src       = w_ctrl.pc_src;
  assign alu_src_a    = w_ctrl.alu_src_a;
  assign alu_src_b    = w_ctrl.alu_src_b;
  assign alu_op       = w_ctrl.alu_op;
  assign ext_type     = w_ctrl.ext_type;
  assign reg_dst      = w_ctrl.reg_dst;
  assign mem_to_reg   = w_ctrl.mem_to_reg;
  assign reg_write    = w_ctrl.reg_write;
  assign illegal      = w_ctrl.illegal;
  assign retire       = w_ctrl.retire;
  assign retired_cnt  = r_retired_cnt;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction is expanded into the
// sequence of expected control vectors and compared cycle by cycle.
module tb_multicycle_ctrl;

  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [5:0]       opcode = '0;
  logic [5:0]       funct = '0;
  logic             alu_zero = 1'b0;
  logic             ir_write, pc_write, alu_src_a, reg_write, illegal, retire;
  logic [1:0]       pc_src, alu_src_b, ext_type, reg_dst, mem_to_reg;
  logic [2:0]       alu_op;
  logic [CNT_W-1:0] retired_cnt;

  multicycle_ctrl_if mem_if ();

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .funct       (funct),
    .alu_zero    (alu_zero),
    .mem         (mem_if),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op      (alu_op),
    .ext_type    (ext_type),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .illegal     (illegal),
    .retire      (retire),
    .retired_cnt (retired_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mreq, mwe, iod, irw, pcw;
    logic [1:0] pcs;
    logic       asa;
    logic [1:0] asb;
    logic [2:0] aop;
    logic [1:0] ext, rdst, m2r;
    logic       rw, ill, ret;
  } vec_t;

  // kind: 0 plain, 1 fetch access, 2 data access, 3 conditional branch
  typedef struct {
    vec_t v;
    int   kind;
  } step_t;

  typedef enum int {
    K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_XOR, K_ADDI, K_ADDIU, K_ORI, K_LUI,
    K_LW, K_SW, K_BEQ, K_J, K_JAL, K_BAD, K_BADR
  } kind_e;

  step_t       steps[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] model_cnt = '0;

  function automatic vec_t obs();
    return vec_t'({mem_if.mem_req, mem_if.mem_we, mem_if.i_or_d, ir_write, pc_write,
                   pc_src, alu_src_a, alu_src_b, alu_op, ext_type, reg_dst,
                   mem_to_reg, reg_write, illegal, retire});
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input vec_t v, input int kind);
    step_t s;
    s.v    = v;
    s.kind = kind;
    steps.push_back(s);
  endtask

  task automatic enc(input kind_e k, output logic [5:0] op, output logic [5:0] fn);
    fn = 6'($urandom);
    op = 6'b000000;
    case (k)
      K_ADD:   fn = 6'b100000;
      K_SUB:   fn = 6'b100010;
      K_AND:   fn = 6'b100100;
      K_OR:    fn = 6'b100101;
      K_SLT:   fn = 6'b101010;
      K_XOR:   fn = 6'b100110;
      K_ADDI:  op = 6'b001000;
      K_ADDIU: op = 6'b001001;
      K_ORI:   op = 6'b001101;
      K_LUI:   op = 6'b001111;
      K_LW:    op = 6'b100011;
      K_SW:    op = 6'b101011;
      K_BEQ:   op = 6'b000100;
      K_J:     op = 6'b000010;
      K_JAL:   op = 6'b000011;
      K_BAD:   op = 6'b111111;
      default: begin
        case ($urandom_range(0, 3))
          0:       fn = 6'b000000;
          1:       fn = 6'b100001;
          2:       fn = 6'b100011;
          default: fn = 6'b001000;
        endcase
      end
    endcase
  endtask

  // Expected control vector per cycle, written from the instruction's phases
  task automatic build(input kind_e k);
    vec_t v;
    steps.delete();
    v = '0; v.mreq = 1; v.asb = 2'b01; v.irw = 1; v.pcw = 1;
    push(v, 1);
    v = '0; v.asb = 2'b11;
    if (k == K_J || k == K_JAL) begin
      v.pcw = 1; v.pcs = 2'b10; v.ret = 1;
      if (k == K_JAL) begin v.rw = 1; v.rdst = 2'b10; v.m2r = 2'b10; end
      push(v, 0);
      return;
    end
    push(v, 0);
    if (k == K_BAD || k == K_BADR) begin
      v = '0; v.ill = 1;
      repeat (20) push(v, 0);
      return;
    end
    v = '0; v.asa = 1;
    case (k)
      K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_XOR: begin
        v.asb = 2'b00;
        v.aop = (k == K_SUB) ? 3'd1 : (k == K_OR) ? 3'd2 : (k == K_SLT) ? 3'd3 :
                (k == K_AND) ? 3'd4 : (k == K_XOR) ? 3'd5 : 3'd0;
        push(v, 0);
        v = '0; v.rw = 1; v.rdst = 2'b01; v.m2r = 2'b01; v.ret = 1;
        push(v, 0);
      end
      K_ADDI, K_ADDIU, K_ORI, K_LUI: begin
        v.asb = 2'b10;
        v.aop = (k == K_ORI) ? 3'd2 : 3'd0;
        v.ext = (k == K_ADDIU || k == K_ORI) ? 2'b01 : (k == K_LUI) ? 2'b10 : 2'b00;
        push(v, 0);
        v = '0; v.rw = 1; v.rdst = 2'b00; v.m2r = 2'b01; v.ret = 1;
        push(v, 0);
      end
      K_LW, K_SW: begin
        v.asb = 2'b10;
        push(v, 0);
        v = '0; v.mreq = 1; v.iod = 1;
        if (k == K_SW) begin
          v.mwe = 1; v.ret = 1;
          push(v, 2);
        end else begin
          push(v, 2);
          v = '0; v.rw = 1; v.rdst = 2'b00; v.m2r = 2'b00; v.ret = 1;
          push(v, 0);
        end
      end
      default: begin
        v.asb = 2'b00; v.aop = 3'd1; v.pcs = 2'b01; v.ret = 1;
        push(v, 3);
      end
    endcase
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_if.mem_ready = 1'b0;
    #1;
    chk("reset_outputs", 32'(obs()), 32'd0);
    chk("reset_retired_cnt", retired_cnt, 32'd0);
    model_cnt = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("init_outputs", 32'(obs()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input kind_e k, input int data_waits, input int zero, input bit abort_mem);
    logic [5:0] op, fn;
    vec_t       e;
    int         waits;
    logic       rdy;
    enc(k, op, fn);
    opcode = op;
    funct  = fn;
    build(k);
    foreach (steps[i]) begin
      case (steps[i].kind)
        1:       waits = $urandom_range(0, 2);
        2:       waits = (data_waits >= 0) ? data_waits : $urandom_range(0, 3);
        default: waits = 0;
      endcase
      if (abort_mem && steps[i].kind == 2) waits = 1;
      for (int w = 0; w <= waits; w++) begin
        e   = steps[i].v;
        rdy = (w == waits);
        if (steps[i].kind == 0 || steps[i].kind == 3) rdy = 1'($urandom);
        alu_zero = (zero >= 0 && steps[i].kind == 3) ? zero[0] : 1'($urandom);
        mem_if.mem_ready = rdy;
        if (!rdy && (steps[i].kind == 1 || steps[i].kind == 2)) begin
          e.irw = 0; e.pcw = 0; e.ret = 0;
        end
        if (steps[i].kind == 3) e.pcw = alu_zero;
        @(negedge clk);
        chk($sformatf("%s.step%0d.wait%0d", k.name(), i, w), 32'(obs()), 32'(e));
        chk($sformatf("%s.step%0d.retired_cnt", k.name(), i), retired_cnt, model_cnt);
        if (abort_mem && steps[i].kind == 2) begin
          do_reset();
          return;
        end
        @(posedge clk);
        #1;
        if (e.ret) model_cnt++;
      end
    end
  endtask

  initial begin
    mem_if.mem_ready = 1'b0;
    #3;
    do_reset();
    run(K_ADD, -1, -1, 1'b0);
    run(K_LW, 3, -1, 1'b0);
    run(K_BEQ, -1, 1, 1'b0);
    run(K_BEQ, -1, 0, 1'b0);
    run(K_JAL, -1, -1, 1'b0);
    repeat (300) run(kind_e'($urandom_range(0, 14)), -1, -1, 1'b0);
    run(K_SW, -1, -1, 1'b1);
    run(K_ADD, -1, -1, 1'b0);
    run(K_BAD, -1, -1, 1'b0);
    do_reset();
    run(K_ORI, -1, -1, 1'b0);
    run(K_BADR, -1, -1, 1'b0);
    do_reset();
    repeat (40) run(kind_e'($urandom_range(0, 14)), -1, -1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle sequencer for the MIPS datapath. It replaces per-instruction single-cycle decode with a state machine that steps each instruction through FETCH, DECODE, EXEC, MEM and WB. It shares one memory port between instruction fetch and data access through a req/ready handshake. It sits beside the datapath: it reads opcode/funct from the datapath's instruction register and the ALU zero flag, and drives every mux select and write enable.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; asynchronous and active-low
- opcode  in  6  IR[31:26], held stable by the datapath from FETCH completion to the next FETCH
- funct  in  6  IR[5:0]
- alu_zero  in  1  ALU zero flag, combinational from the datapath
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write strobe, valid with mem_req
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_write  out  1  load IR (and the datapath's MDR) from memory read data
- pc_write  out  1  PC write enable
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut (branch target), 10 = jump target
- alu_src_a  out  1  ALU A: 0 = PC, 1 = rs
- alu_src_b  out  2  ALU B: 00 = rt, 01 = const 4, 10 = ext imm, 11 = sext imm<<2
- alu_op  out  3  Add 000, Sub 001, Or 010, Slt 011, And 100, Xor 101
- ext_type  out  2  signed 00, unsigned 01, lui 10
- reg_dst  out  2  rt 00, rd 01, $ra 10
- mem_to_reg  out  2  read data 00, ALU result 01, PC 10
- reg_write  out  1  register-file write enable
- illegal  out  1  sticky undefined-instruction flag
- retire  out  1  one-cycle pulse when an instruction completes
- retired_cnt  out  CNT_W  count of completed instructions

## Operation
- States: INIT, FETCH, DECODE, EXEC, MEM, WB, TRAP. 3-bit encoding.
- Unless listed for a state, every output is 0.
- **INIT.** All outputs 0. Goes to FETCH unconditionally.
- **FETCH.** mem_req=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=Add.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=00, then DECODE.
  - Otherwise stay in FETCH.
- **DECODE.** alu_src_a=0, alu_src_b=11, alu_op=Add (precomputes the branch target). The instruction class is registered here.
  - Undefined opcode/funct: go to TRAP.
  - j: pc_write=1, pc_src=10, retire, then FETCH.
  - jal: as j, plus reg_write=1, reg_dst=10, mem_to_reg=10.
  - All others: EXEC.
- **EXEC.**
  - R-type (add/sub/and/or/slt/xor): alu_src_a=1, alu_src_b=00, alu_op per funct, then WB.
  - addi: alu_src_a=1, alu_src_b=10, alu_op=Add, ext_type=00, then WB.
  - addiu: as addi with ext_type=01.
  - ori: as addi with alu_op=Or, ext_type=01.
  - lui: as addi with ext_type=10.
  - lw/sw: alu_src_a=1, alu_src_b=10, alu_op=Add, ext_type=00, then MEM.
  - beq: alu_src_a=1, alu_src_b=00, alu_op=Sub. pc_write=alu_zero, pc_src=01, retire, then FETCH.
- **MEM.** mem_req=1, i_or_d=1, mem_we=1 for sw.
  - On mem_ready: sw retires and goes to FETCH; lw goes to WB.
  - Otherwise hold, with all outputs unchanged.
- **WB.** reg_write=1, retire, then FETCH.
  - R-type: reg_dst=01, mem_to_reg=01.
  - I-type arithmetic: reg_dst=00, mem_to_reg=01.
  - lw: reg_dst=00, mem_to_reg=00.
- **TRAP.** illegal=1, all enables 0. Exited only by reset.
- retired_cnt increments on retire and wraps modulo 2^CNT_W.

## Timing
- Reset (rst_n low, asynchronous): state=INIT, retired_cnt=0, class register cleared, so every output reads 0.
  - Reset asserted mid-instruction aborts it immediately; any pending mem_req drops in the same cycle.
  - First mem_req is asserted in the second cycle after rst_n deasserts.
- Outputs decode combinationally from state, class register and inputs. Only ir_write, pc_write (FETCH), retire and MEM exit are gated by mem_ready or alu_zero.
- Handshake:
  - mem_req, mem_we, i_or_d and the address selects stay stable until the cycle in which mem_ready is high.
  - One access completes per mem_ready cycle; mem_ready outside FETCH/MEM is ignored.
- Latency with mem_ready always high: j/jal 2, beq 3, R-type/I-type/sw 4, lw 5 cycles. Each wait cycle adds 1.
- retire is asserted in the final cycle of an instruction; retired_cnt shows the new value on the next edge.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - the alu_op, ext_type, reg_dst, mem_to_reg and pc_src encodings;
  - opcode and funct constants;
  - the state enum;
  - the instruction-class enum.
- One sub-module, `instr_class_dec`: combinational opcode/funct to class, plus a valid bit.

## Test plan
- Reset, then add (opcode 000000, funct 100000) with mem_ready=1:
  - FETCH, DECODE, EXEC (alu_op=000, alu_src_b=00), WB (reg_dst=01, reg_write=1);
  - retired_cnt goes 0 to 1.
- lw with mem_ready low for 3 cycles in MEM:
  - MEM held 3 cycles with mem_req=1, i_or_d=1, mem_we=0;
  - then WB with mem_to_reg=00; 8 cycles total.
- beq with alu_zero=1, then beq with alu_zero=0:
  - pc_write=1, pc_src=01 in EXEC for the first; pc_write=0 for the second;
  - both take 3 cycles and both retire.
- jal: DECODE asserts pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10; next state is FETCH.
- opcode 111111: TRAP after DECODE, illegal=1; no mem_req for 20 cycles; rst_n low clears it.
- rst_n asserted while in MEM for sw with mem_req=1: mem_we/mem_req drop the same cycle, state=INIT, retired_cnt=0.
